ccff_bitstream_loader: RTL and testbench

//  Upstream feeder of the configuration-chain (ccff_head -> ccff_tail) of the connection/switch blocks.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_crc16.sv | 28 ++
 rtl/ccff_bitstream_loader.sv | 139 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// Latency: n/a (types only).
// Backpressure: n/a.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT, one bit per enabled cycle; clr reloads the init value.
// Latency: crc reflects a bit the cycle after it is presented with en=1.
// Backpressure: none; updates only when en is high.
module ccff_crc16
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises valid/ready bitstream words LSB-first onto the config chain head; optional CRC check under CCFF_CRC_EN.
// Latency: first bit on ccff_head/chain_clk_en the cycle after the word handshake; one bubble per word fetch.
// Backpressure: cfg_ready only in FETCH/CHECK; with cfg_valid low the chain is frozen (chain_clk_en=0, head held).
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 62
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t              state;
    logic [WORD_W-1:0]   sh;
    logic [WC_W-1:0]     wcnt;
    logic [CNT_W-1:0]    bits_left;
    logic [WC_W-1:0]     first_cnt;
    logic                start_ok;
    logic                hs;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign hs       = cfg_valid && cfg_ready;

    // Bits still to take from the incoming word, minus one; the last word is truncated.
    always_comb begin
        first_cnt = WC_W'(WORD_W - 1);
        if (int'(bits_left) < WORD_W) begin
            first_cnt = WC_W'(int'(bits_left) - 1);
        end
    end

`ifdef CCFF_CRC_EN
    logic [15:0] crc;

    ccff_crc16 u_crc (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clr      (start_ok),
        .en       (chain_clk_en),
        .din      (ccff_head),
        .crc      (crc)
    );
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state        <= IDLE;
            cfg_ready    <= 1'b0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sh           <= '0;
            wcnt         <= '0;
            bits_left    <= '0;
`ifdef CCFF_CRC_EN
            err          <= 1'b0;
`endif
        end else begin
            chain_clk_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= FETCH;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bits_left <= CNT_W'(CHAIN_LEN);
`ifdef CCFF_CRC_EN
                        err       <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (hs) begin
                        state        <= SHIFT;
                        cfg_ready    <= 1'b0;
                        ccff_head    <= cfg_data[0];
                        chain_clk_en <= 1'b1;
                        sh           <= cfg_data >> 1;
                        wcnt         <= first_cnt;
                        bits_left    <= bits_left - CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (wcnt != '0) begin
                        ccff_head    <= sh[0];
                        chain_clk_en <= 1'b1;
                        sh           <= sh >> 1;
                        wcnt         <= wcnt - WC_W'(1);
                        bits_left    <= bits_left - CNT_W'(1);
                    end else if (bits_left != '0) begin
                        state     <= FETCH;
                        cfg_ready <= 1'b1;
                    end else begin
`ifdef CCFF_CRC_EN
                        state     <= CHECK;
                        cfg_ready <= 1'b1;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
`endif
                    end
                end
`ifdef CCFF_CRC_EN
                CHECK: begin
                    if (hs) begin
                        state     <= DONE;
                        cfg_ready <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        err       <= (cfg_data[15:0] != crc);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised bench for ccff_bitstream_loader against a word-list/bit-stream reference model.
// Latency: n/a. Backpressure: bench withholds cfg_valid to exercise FETCH stalls.
module tb_ccff_bitstream_loader;

    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 62;

    logic              prog_clk = 1'b0;
    logic              pReset_n;
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              chain_clk_en;
    logic              busy;
    logic              done;
    logic              err;

    ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk     (prog_clk),
        .pReset_n     (pReset_n),
        .start        (start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .chain_clk_en (chain_clk_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 prog_clk = ~prog_clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_rises = 0;
    int   inject_at  = -1;
    bit   bitq[$];
    int   en_cyc[$];
    int   hs_cyc[$];
    logic done_q = 1'b0;
    logic head_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: mid-cycle sampling of the chain interface plus protocol invariants.
    always @(negedge prog_clk) begin
        cyc++;
        if (pReset_n) begin
            if (chain_clk_en) begin
                bitq.push_back(ccff_head);
                en_cyc.push_back(cyc);
            end
            if (cfg_valid && cfg_ready) hs_cyc.push_back(cyc);
            if (done && !done_q) done_rises++;
            if (done && busy) check("done_busy_excl", 64'(done & busy), 64'd0);
            if (chain_clk_en && !busy) check("en_without_busy", 64'(chain_clk_en), 64'd0);
            if (cfg_ready) begin
                check("en_in_fetch", 64'(chain_clk_en), 64'd0);
                check("head_hold", 64'(ccff_head), 64'(head_q));
            end
        end
        done_q = done;
        head_q = ccff_head;
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        if (inject_at >= 0 && bitq.size() >= inject_at) begin
            start     = 1'b1;
            inject_at = -1;
        end
    endtask

    // CRC-16-CCITT, MSB-first polynomial division over the bits in shift order.
    function automatic logic [15:0] model_crc(input logic [63:0] v, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic run_load(input logic [31:0] w0, input logic [31:0] w1,
                            input int s0, input int s1, input int inj,
                            input logic [15:0] crc_xor);
        logic [31:0] words[$];
        int          stalls[$];
        logic [63:0] exp_vec;
        logic [63:0] got_vec;
        logic        exp_err;
        int          t;
        int          st;
        bit          hs;

        exp_vec = {w1, w0} & ((64'd1 << CHAIN_LEN) - 64'd1);
        words   = '{w0, w1};
        stalls  = '{s0, s1};
        exp_err = 1'b0;
`ifdef CCFF_CRC_EN
        words.push_back({16'($urandom), model_crc(exp_vec, CHAIN_LEN) ^ crc_xor});
        stalls.push_back(s1);
        exp_err = (crc_xor != 16'h0000);
`else
        if (crc_xor != 16'h0000) exp_err = 1'b0;
`endif
        bitq.delete();
        en_cyc.delete();
        hs_cyc.delete();
        done_rises = 0;

        start = 1'b1;
        tick();
        inject_at = inj;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_clr", 64'(done), 64'd0);
        check("err_clr", 64'(err), 64'd0);

        foreach (words[k]) begin
            cfg_valid = 1'b0;
            st = 0;
            t  = 0;
            while (st < stalls[k] && t < 300) begin
                @(negedge prog_clk);
                if (cfg_ready) st++;
                tick();
                t++;
            end
            cfg_valid = 1'b1;
            cfg_data  = words[k];
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 300) begin
                @(negedge prog_clk);
                hs = cfg_ready;
                tick();
                t++;
            end
            check("handshake_seen", 64'(hs), 64'd1);
            cfg_valid = 1'b0;
            cfg_data  = $urandom;
        end

        t = 0;
        while (!done && t < 300) begin
            tick();
            t++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge prog_clk);
        #1;
        inject_at = -1;

        got_vec = '0;
        for (int i = 0; i < CHAIN_LEN && i < bitq.size(); i++) got_vec[i] = bitq[i];
        check("bit_count", 64'(bitq.size()), 64'(CHAIN_LEN));
        check("stream", got_vec, exp_vec);
        check("handshakes", 64'(hs_cyc.size()), 64'(words.size()));
        check("done_pulses", 64'(done_rises), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("err", 64'(err), 64'(exp_err));
        if (en_cyc.size() > WORD_W && hs_cyc.size() > 1) begin
            check("first_bit_lat", 64'(en_cyc[0]), 64'(hs_cyc[0] + 1));
            check("word2_lat", 64'(en_cyc[WORD_W]), 64'(hs_cyc[1] + 1));
        end else begin
            check("latency_samples", 64'(en_cyc.size()), 64'(CHAIN_LEN));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        pReset_n  = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_head", 64'(ccff_head), 64'd0);
        check("rst_clk_en", 64'(chain_clk_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        pReset_n = 1'b1;
        repeat (2) tick();
        check("idle_ready", 64'(cfg_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        run_load(32'hA5A5_0F0F, 32'h3FFF_FFFF, 0, 0, -1, 16'h0000);
        run_load($urandom, $urandom, 0, 5, -1, 16'h0000);
        run_load($urandom, $urandom, 0, 0, 10, 16'h0000);

        // Asynchronous reset mid-load, followed by a full reload.
        bitq.delete();
        start = 1'b1;
        tick();
        cfg_valid = 1'b1;
        cfg_data  = $urandom;
        t = 0;
        while (bitq.size() < 20 && t < 200) begin
            tick();
            t++;
        end
        check("pre_reset_bits", 64'(bitq.size()), 64'd20);
        #1;
        pReset_n = 1'b0;
        #1;
        check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("mid_rst_head", 64'(ccff_head), 64'd0);
        check("mid_rst_clk_en", 64'(chain_clk_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        cfg_valid = 1'b0;
        repeat (2) tick();
        pReset_n = 1'b1;
        tick();
        run_load($urandom, $urandom, 1, 2, -1, 16'h0000);

        for (int r = 0; r < 5; r++) begin
            run_load($urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 6), -1, 16'h0000);
        end

`ifdef CCFF_CRC_EN
        run_load($urandom, $urandom, 0, 0, -1, 16'h0000);
        run_load($urandom, $urandom, 0, 1, -1, 16'h0001);
        run_load($urandom, $urandom, 2, 0, -1, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
